// File: rtl/dual_port_init_ram_if.sv
// Bus bundle for dual_port_init_ram.
// Port A: read/write with byte enables (a_cs, a_we, a_be, a_addr, a_wdata -> a_rdata, a_rvalid).
// Port B: read only (b_cs, b_addr -> b_rdata, b_rvalid).
// init_busy: high while the post-reset clear sequence runs.
// master drives requests; slave is the RAM.
interface dual_port_init_ram_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                    a_cs;
    logic                    a_we;
    logic [DATA_WIDTH/8-1:0] a_be;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [DATA_WIDTH-1:0]   a_rdata;
    logic                    a_rvalid;
    logic                    b_cs;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_rdata;
    logic                    b_rvalid;
    logic                    init_busy;

    modport master (
        output a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, init_busy
    );

    modport slave (
        input  a_cs, a_we, a_be, a_addr, a_wdata, b_cs, b_addr,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, init_busy
    );
endinterface

// File: rtl/dual_port_init_ram.sv
// Synchronous dual-port RAM with hardware clear after reset.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; restarts the clear sequence
//   bus  - dual_port_init_ram_if.slave: port A read/write with byte enables,
//          port B read only, registered 1-cycle reads with rvalid pulses,
//          init_busy while the clear sequence writes INIT_VALUE to every word.
// Out-of-range addresses (>= LENGTH) drop writes and read back 0.
// BYPASS=1 forwards a same-edge port A write to a port B read of the same word.
module dual_port_init_ram #(
    parameter int                        ADDR_WIDTH = 12,
    parameter int                        DATA_WIDTH = 16,
    parameter int                        LENGTH     = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0,
    parameter int                        BYPASS     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    dual_port_init_ram_if.slave     bus
);
    localparam int unsigned             NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ADDR_WIDTH:0]     LEN_EXT   = (ADDR_WIDTH + 1)'(LENGTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_next;
    logic [DATA_WIDTH-1:0]   mem [LENGTH];

    logic                    a_in_range, b_in_range;
    logic                    a_wr;
    logic                    b_hit;
    logic [DATA_WIDTH-1:0]   a_merged;
    logic [DATA_WIDTH-1:0]   b_word;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_next;
        end
    end

    // FSM: next state; the clear counter advances one word per INIT cycle
    always_comb begin
        state_next = state;
        clr_next   = clr_addr;
        case (state)
            ST_INIT: begin
                clr_next = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign bus.init_busy = (state == ST_INIT);

    assign a_in_range = ({1'b0, bus.a_addr} < LEN_EXT);
    assign b_in_range = ({1'b0, bus.b_addr} < LEN_EXT);
    assign a_wr       = (state == ST_RUN) && bus.a_cs && bus.a_we && a_in_range;
    assign b_hit      = a_wr && (bus.a_addr == bus.b_addr);

    // Word as it will look after this edge's port A write; only feeds the bypass path
    always_comb begin
        a_merged = a_in_range ? mem[bus.a_addr] : '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (bus.a_be[i]) begin
                a_merged[8*i +: 8] = bus.a_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        b_word = '0;
        if (b_in_range) begin
            b_word = ((BYPASS != 0) && b_hit) ? a_merged : mem[bus.b_addr];
        end
    end

    // Storage: clear writes in INIT, byte-lane writes from port A in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[clr_addr] <= INIT_VALUE;
            end else if (a_wr) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (bus.a_be[i]) begin
                        mem[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read ports; rdata holds when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a_rdata  <= '0;
            bus.a_rvalid <= 1'b0;
            bus.b_rdata  <= '0;
            bus.b_rvalid <= 1'b0;
        end else begin
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            if (state == ST_RUN) begin
                if (bus.a_cs && !bus.a_we) begin
                    bus.a_rvalid <= 1'b1;
                    bus.a_rdata  <= a_in_range ? mem[bus.a_addr] : '0;
                end
                if (bus.b_cs) begin
                    bus.b_rvalid <= 1'b1;
                    bus.b_rdata  <= b_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_dual_port_init_ram.sv
// Testbench for dual_port_init_ram: two builds driven by the same stimulus.
//   dut0: LENGTH=16, INIT_VALUE=A5A5, BYPASS=1
//   dut1: LENGTH=12, INIT_VALUE=0F0F, BYPASS=0
module tb_dual_port_init_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_cs, a_we, b_cs;
    logic [1:0]  a_be;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_port_init_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if0 ();
    dual_port_init_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if1 ();

    assign if0.a_cs = a_cs;   assign if1.a_cs = a_cs;
    assign if0.a_we = a_we;   assign if1.a_we = a_we;
    assign if0.a_be = a_be;   assign if1.a_be = a_be;
    assign if0.a_addr = a_addr;   assign if1.a_addr = a_addr;
    assign if0.a_wdata = a_wdata; assign if1.a_wdata = a_wdata;
    assign if0.b_cs = b_cs;   assign if1.b_cs = b_cs;
    assign if0.b_addr = b_addr;   assign if1.b_addr = b_addr;

    dual_port_init_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .LENGTH(16),
        .INIT_VALUE(16'hA5A5), .BYPASS(1)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    dual_port_init_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .LENGTH(12),
        .INIT_VALUE(16'h0F0F), .BYPASS(0)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [15:0] g_ar [2];
    logic [15:0] g_br [2];
    logic        g_av [2];
    logic        g_bv [2];
    logic        g_busy [2];
    assign g_ar[0] = if0.a_rdata;   assign g_ar[1] = if1.a_rdata;
    assign g_br[0] = if0.b_rdata;   assign g_br[1] = if1.b_rdata;
    assign g_av[0] = if0.a_rvalid;  assign g_av[1] = if1.a_rvalid;
    assign g_bv[0] = if0.b_rvalid;  assign g_bv[1] = if1.b_rvalid;
    assign g_busy[0] = if0.init_busy; assign g_busy[1] = if1.init_busy;

    // Reference model: per-build word array plus clear progress
    int          m_len  [2];
    int          m_byp  [2];
    logic [15:0] m_init [2];
    logic [15:0] m_mem  [2][16];
    int          m_cnt  [2];
    bit          m_busy [2];
    logic [15:0] m_ar   [2];
    logic [15:0] m_br   [2];
    bit          m_av   [2];
    bit          m_bv   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [15:0] mask, old_a, old_b, neww;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 1'b1; m_cnt[d] = 0;
                m_ar[d] = '0; m_br[d] = '0; m_av[d] = 0; m_bv[d] = 0;
            end else if (m_busy[d]) begin
                m_mem[d][m_cnt[d]] = m_init[d];
                if (m_cnt[d] == m_len[d] - 1) m_busy[d] = 0;
                m_cnt[d]++;
                m_av[d] = 0; m_bv[d] = 0;
            end else begin
                old_a = (int'(a_addr) < m_len[d]) ? m_mem[d][a_addr] : 16'h0;
                old_b = (int'(b_addr) < m_len[d]) ? m_mem[d][b_addr] : 16'h0;
                mask  = {{8{a_be[1]}}, {8{a_be[0]}}};
                neww  = (old_a & ~mask) | (a_wdata & mask);
                m_av[d] = a_cs && !a_we;
                m_bv[d] = b_cs;
                if (m_av[d]) m_ar[d] = old_a;
                if (m_bv[d]) begin
                    m_br[d] = old_b;
                    if (m_byp[d] != 0 && a_cs && a_we && a_addr == b_addr && int'(a_addr) < m_len[d])
                        m_br[d] = neww;
                end
                if (a_cs && a_we && int'(a_addr) < m_len[d]) m_mem[d][a_addr] = neww;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy%0d", d),    32'(g_busy[d]), 32'(m_busy[d]));
            check($sformatf("a_rvalid%0d", d), 32'(g_av[d]),  32'(m_av[d]));
            check($sformatf("b_rvalid%0d", d), 32'(g_bv[d]),  32'(m_bv[d]));
            check($sformatf("a_rdata%0d", d),  32'(g_ar[d]),  32'(m_ar[d]));
            check($sformatf("b_rdata%0d", d),  32'(g_br[d]),  32'(m_br[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 0; a_cs = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_cs = 0; b_addr = '0;
    endtask

    task automatic wr_a(input logic [3:0] ad, input logic [15:0] dt, input logic [1:0] be);
        a_cs = 1; a_we = 1; a_addr = ad; a_wdata = dt; a_be = be;
    endtask

    task automatic rd_a(input logic [3:0] ad);
        a_cs = 1; a_we = 0; a_addr = ad; a_be = $urandom;
    endtask

    task automatic rd_b(input logic [3:0] ad);
        b_cs = 1; b_addr = ad;
    endtask

    initial begin
        int n0, n1;
        m_len[0] = 16; m_byp[0] = 1; m_init[0] = 16'hA5A5;
        m_len[1] = 12; m_byp[1] = 0; m_init[1] = 16'h0F0F;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1; m_cnt[d] = 0;
            m_ar[d] = '0; m_br[d] = '0; m_av[d] = 0; m_bv[d] = 0;
        end

        // Clear sequence with requests issued during INIT
        idle(); rst = 1;
        step(); step();
        rst = 0;
        n0 = 0; n1 = 0;
        while ((g_busy[0] || g_busy[1]) && n0 < 40) begin
            if (n0 < 10) begin wr_a(4'd0, 16'hBEEF, 2'b11); rd_b(4'd0); end
            else idle();
            step();
            n0++;
            if (g_busy[1]) n1++;
        end
        check("init_len0", 32'(n0), 32'd16);
        check("init_len1", 32'(n1 + 1), 32'd12);
        idle();

        // Port B sweep of all addresses, back to back
        for (int i = 0; i < 16; i++) begin rd_b(4'(i)); step(); end
        idle(); step();
        rd_a(4'd0); step();
        check("init_val0", 32'(g_ar[0]), 32'h0000A5A5);
        check("init_val1", 32'(g_ar[1]), 32'h00000F0F);

        // Byte-enable merge
        idle(); wr_a(4'd3, 16'h1234, 2'b11); step();
        wr_a(4'd3, 16'hFF00, 2'b10); step();
        idle(); rd_a(4'd3); step();
        check("merge0", 32'(g_ar[0]), 32'h0000FF34);
        check("merge1", 32'(g_ar[1]), 32'h0000FF34);
        idle(); wr_a(4'd3, 16'hAAAA, 2'b00); step();
        idle(); rd_a(4'd3); step();
        check("be_zero0", 32'(g_ar[0]), 32'h0000FF34);

        // Same-edge collision
        idle(); wr_a(4'd5, 16'h1111, 2'b11); step();
        wr_a(4'd5, 16'h2222, 2'b11); rd_b(4'd5); step();
        check("coll_byp1", 32'(g_br[0]), 32'h00002222);
        check("coll_byp0", 32'(g_br[1]), 32'h00001111);
        idle(); rd_b(4'd5); step();
        check("coll_after0", 32'(g_br[0]), 32'h00002222);
        check("coll_after1", 32'(g_br[1]), 32'h00002222);

        // Write then read next cycle on port A
        idle(); wr_a(4'd7, 16'h5A5A, 2'b11); step();
        idle(); rd_a(4'd7); step();

        // Out of range on the 12-word build
        idle(); wr_a(4'd13, 16'h7777, 2'b11); step();
        idle(); rd_a(4'd13); rd_b(4'd13); step();
        check("oor_a1", 32'(g_ar[1]), 32'h0);
        check("oor_b1", 32'(g_br[1]), 32'h0);
        check("oor_av1", 32'(g_av[1]), 32'h1);
        check("oor_bv1", 32'(g_bv[1]), 32'h1);
        check("oor_a0", 32'(g_ar[0]), 32'h00007777);
        idle();
        for (int i = 0; i < 16; i++) begin rd_a(4'(i)); rd_b(4'(15 - i)); step(); end

        // Reset during RUN with reads pending
        idle(); rd_a(4'd5); rd_b(4'd5); rst = 1; step();
        check("rst_run_av0", 32'(g_av[0]), 32'h0);
        check("rst_run_br0", 32'(g_br[0]), 32'h0);
        check("rst_run_busy1", 32'(g_busy[1]), 32'h1);
        idle();
        for (int i = 0; i < 7; i++) step();
        // Reset again 7 cycles into the clear
        rst = 1; step();
        rst = 0;
        n0 = 0;
        while (g_busy[0] && n0 < 40) begin step(); n0++; end
        check("reinit_len0", 32'(n0), 32'd16);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            a_cs    = $urandom_range(0, 1);
            a_we    = $urandom_range(0, 1);
            a_be    = 2'($urandom);
            a_addr  = 4'($urandom);
            a_wdata = 16'($urandom);
            b_cs    = $urandom_range(0, 1);
            b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom);
            step();
        end
        idle(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
